// File: rtl/bash_io_pkg.sv
// Shared constants, buffer geometry and state encoding for the line port.
package bash_io_pkg;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  localparam int LINE_MAX_DEF = 31;
  localparam int BUF_AW       = 5;
  localparam int BUF_DEPTH    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // Anything that is not a control code we act on goes into the line.
  function automatic logic is_printable(input logic [7:0] c);
    return (c != ASCII_NUL) && (c != ASCII_BS) && (c != ASCII_CR);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// 32x8 character store: one synchronous write port, one asynchronous read port.
module line_buffer
  import bash_io_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [BUF_AW-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [BUF_AW-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [0:BUF_DEPTH-1];

  // Contents need no reset; only indices below the line length are ever read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bash_line_port.sv
// Line editor between keyboard, text screen and a command application.
//
// Handshakes (all sampled on posedge clk):
//   keyboard : a key is taken in a cycle with kbd_valid=1 and kbd_ready=1.
//   screen   : scr_we/scr_ascii are held until a cycle with scr_busy=0 takes them.
//   line out : out_newASCII_ready=1 presents lineOut; lineOut_nextASCII=1 consumes
//              one character, the trailing 0x00 terminator ends the transfer.
//   line in  : lineIn_nextASCII=1 consumes lineIn; never asserted two cycles running.
module bash_line_port
  import bash_io_pkg::*;
#(
  parameter int LINE_MAX = LINE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_ascii,
  output logic       kbd_ready,
  output logic       out_newASCII_ready,
  output logic [5:0] out_lineLen,
  output logic [7:0] lineOut,
  input  logic       lineOut_nextASCII,
  input  logic       in_newASCII_ready,
  input  logic [7:0] lineIn,
  output logic       lineIn_nextASCII,
  input  logic       in_solved,
  output logic       out_solved,
  output logic       scr_we,
  output logic [7:0] scr_ascii,
  input  logic       scr_busy,
  output state_t     o_dbg_state
);

  localparam logic [5:0] LEN_MAX = 6'(LINE_MAX);

  state_t     r_state, w_state_nx;
  logic       r_out_en;
  logic [5:0] r_len, w_len_nx;
  logic [5:0] r_rd_idx, w_rd_idx_nx;
  logic [5:0] r_line_len, w_line_len_nx;
  logic       r_scr_we;
  logic [7:0] r_scr_ascii;
  logic       w_scr_load;
  logic [7:0] w_scr_data;
  logic       r_solved, w_solved_nx;
  logic       r_ack_done, w_ack_done_nx;
  logic       r_prev_next;
  logic       w_recv_fire;
  logic       w_buf_we;
  logic [7:0] w_rd_data;
  logic       w_kbd_take;
  logic       w_scr_free;
  logic       w_rd_in_range;

  line_buffer u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_len[BUF_AW-1:0]),
    .i_wdata (kbd_ascii),
    .i_raddr (r_rd_idx[BUF_AW-1:0]),
    .o_rdata (w_rd_data)
  );

  // r_out_en holds keyboard ready low until the first edge after reset release.
  assign kbd_ready          = r_out_en && (r_state == ST_IDLE) && !scr_busy;
  assign w_kbd_take         = kbd_valid && kbd_ready;
  assign w_scr_free         = !r_scr_we || !scr_busy;
  assign w_rd_in_range      = (r_rd_idx < r_line_len);
  assign out_newASCII_ready = (r_state == ST_SEND);
  assign out_lineLen        = r_line_len;
  assign lineOut            = (out_newASCII_ready && w_rd_in_range) ? w_rd_data : ASCII_NUL;
  assign lineIn_nextASCII   = w_recv_fire;
  assign out_solved         = r_solved;
  assign scr_we             = r_scr_we || w_recv_fire;
  assign scr_ascii          = w_recv_fire ? lineIn : r_scr_ascii;
  assign o_dbg_state        = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state and datapath control for editing, sending, receiving and ack.
  always_comb begin
    w_state_nx    = r_state;
    w_len_nx      = r_len;
    w_rd_idx_nx   = r_rd_idx;
    w_line_len_nx = r_line_len;
    w_scr_load    = 1'b0;
    w_scr_data    = r_scr_ascii;
    w_solved_nx   = 1'b0;
    w_ack_done_nx = r_ack_done;
    w_recv_fire   = 1'b0;
    w_buf_we      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_kbd_take) begin
          if (kbd_ascii == ASCII_CR) begin
            w_scr_load    = 1'b1;
            w_scr_data    = ASCII_CR;
            w_line_len_nx = r_len;
            w_rd_idx_nx   = 6'd0;
            w_state_nx    = ST_SEND;
          end else if (kbd_ascii == ASCII_BS) begin
            if (r_len != 6'd0) begin
              w_len_nx   = r_len - 6'd1;
              w_scr_load = 1'b1;
              w_scr_data = ASCII_BS;
            end
          end else if (is_printable(kbd_ascii) && (r_len < LEN_MAX)) begin
            w_buf_we   = 1'b1;
            w_len_nx   = r_len + 6'd1;
            w_scr_load = 1'b1;
            w_scr_data = kbd_ascii;
          end
        end
      end
      ST_SEND: begin
        if (lineOut_nextASCII) begin
          if (w_rd_in_range) begin
            w_rd_idx_nx = r_rd_idx + 6'd1;
          end else begin
            w_len_nx   = 6'd0;
            w_state_nx = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        // A pending echo keeps the screen port, so a new character waits for it.
        w_recv_fire = in_newASCII_ready && (lineIn != ASCII_NUL) && !scr_busy &&
                      !r_prev_next && !r_scr_we;
        if (in_solved) begin
          w_solved_nx   = 1'b1;
          w_ack_done_nx = 1'b0;
          w_state_nx    = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!r_ack_done) begin
          if (w_scr_free) begin
            w_scr_load    = 1'b1;
            w_scr_data    = ASCII_CR;
            w_ack_done_nx = 1'b1;
          end
        end else if (w_scr_free && !in_solved) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Datapath registers: line length, read index, screen write holding, pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_en    <= 1'b0;
      r_len       <= 6'd0;
      r_rd_idx    <= 6'd0;
      r_line_len  <= 6'd0;
      r_scr_we    <= 1'b0;
      r_scr_ascii <= 8'h00;
      r_solved    <= 1'b0;
      r_ack_done  <= 1'b0;
      r_prev_next <= 1'b0;
    end else begin
      r_out_en    <= 1'b1;
      r_len       <= w_len_nx;
      r_rd_idx    <= w_rd_idx_nx;
      r_line_len  <= w_line_len_nx;
      r_solved    <= w_solved_nx;
      r_ack_done  <= w_ack_done_nx;
      r_prev_next <= w_recv_fire;
      if (w_scr_load) begin
        r_scr_we    <= 1'b1;
        r_scr_ascii <= w_scr_data;
      end else if (r_scr_we && !scr_busy) begin
        r_scr_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bash_line_port.md
BASH_LINE_PORT -- requirements
Module: bash_line_port

Interface
REQ-001 SHALL have parameter LINE_MAX, default 31, meaning maximum number of printable characters in one edited line (terminator excluded).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports kbd_valid in 1 / kbd_ascii in 8 / kbd_ready out 1: one keyboard character per cycle in which kbd_valid and kbd_ready are both 1.
REQ-005 SHALL have ports out_newASCII_ready out 1 / out_lineLen out 6 / lineOut out 8 / lineOut_nextASCII in 1: committed line toward the application.
REQ-006 SHALL have ports in_newASCII_ready in 1 / lineIn in 8 / lineIn_nextASCII out 1: application output string toward the screen.
REQ-007 SHALL have ports in_solved in 1 / out_solved out 1: end-of-command handshake.
REQ-008 SHALL have ports scr_we out 1 / scr_ascii out 8 / scr_busy in 1: character write to the text screen; a write is taken when scr_we=1 and scr_busy=0.

Function
REQ-009 SHALL implement states IDLE, SEND, RECV, ACK.
REQ-010 SHALL, in IDLE only, drive kbd_ready=1; kbd_ready=0 in all other states, and whenever scr_busy=1.
REQ-011 SHALL, in IDLE, store a printable key (not 0x0D, 0x08, 0x00) at index len and increment len, echoing it via scr_we/scr_ascii the next cycle; if len==LINE_MAX the key SHALL be dropped with no echo.
REQ-012 SHALL, in IDLE, on 0x08 with len>0 decrement len and echo 0x08; with len==0 ignore it.
REQ-013 SHALL, in IDLE, on 0x0D echo 0x0D, latch out_lineLen=len, set rd_idx=0 and enter SEND; len==0 is legal (empty line).
REQ-014 SHALL, in SEND, hold out_newASCII_ready=1 and drive lineOut=buffer[rd_idx] when rd_idx<out_lineLen, else 0x00.
REQ-015 SHALL advance rd_idx by 1 on each cycle lineOut_nextASCII=1 while rd_idx<out_lineLen.
REQ-016 SHALL, when lineOut_nextASCII=1 with rd_idx==out_lineLen (terminator consumed), drop out_newASCII_ready at that edge, clear len, and enter RECV.
REQ-017 SHALL, in RECV, when in_newASCII_ready=1, lineIn!=0, scr_busy=0 and lineIn_nextASCII was 0 in the previous cycle, pulse scr_we=1 with scr_ascii=lineIn and lineIn_nextASCII=1 for exactly one cycle.
REQ-018 SHALL never assert lineIn_nextASCII on two consecutive cycles (at most one character per two cycles), and SHALL not consume lineIn==0x00.
REQ-019 SHALL, in RECV, on in_solved=1 enter ACK, including the case of no output characters.
REQ-020 SHALL, on entry to ACK, drive out_solved=1 for exactly one cycle, write 0x0D to the screen (waiting while scr_busy=1), then return to IDLE once in_solved=0.
REQ-021 SHALL drop keyboard input outside IDLE (no buffering, no echo).
REQ-022 SHALL ignore lineOut_nextASCII outside SEND and in_solved outside RECV/ACK.

Reset
REQ-023 SHALL, on rst_n=0 at any time (including mid-SEND/RECV), force state IDLE, len=0, rd_idx=0, and outputs kbd_ready=0, out_newASCII_ready=0, out_lineLen=0, lineIn_nextASCII=0, out_solved=0, scr_we=0, scr_ascii=0; lineOut SHALL read 0x00.
REQ-024 SHALL set kbd_ready=1 in the first cycle after rst_n deasserts; buffer contents are don't-care.

Structure
REQ-025 SHALL take ASCII_NUL=0x00, ASCII_BS=0x08, ASCII_CR=0x0D, default LINE_MAX and the state encoding from a shared package bash_io_pkg.
REQ-026 SHALL place the 32x8 character store in sub-module line_buffer (one write port, one asynchronous read port).

Verification
REQ-027 SHALL cover: keys 'l','s',0x0D -> screen writes 'l','s',0x0D; out_lineLen=2; lineOut 'l','s',0x00 over three nextASCII pulses; ready low the cycle after the third.
REQ-028 SHALL cover: 'a',0x08,0x08,'b',0x0D -> second 0x08 not echoed; line "b", out_lineLen=1.
REQ-029 SHALL cover: 35 printable keys then 0x0D -> 31 echoes, out_lineLen=31, keys 32-35 dropped.
REQ-030 SHALL cover: app returns "hi" with scr_busy=1 for 3 cycles mid-string -> writes 'h','i' only, lineIn_nextASCII never high on consecutive cycles; in_solved -> single out_solved pulse, then 0x0D write, back to IDLE.
REQ-031 SHALL cover: rst_n low during SEND after one nextASCII -> all outputs at reset values, kbd_ready=1 one cycle after release, next line starts at len=0.
